// File: rtl/reg_spill_if.sv
// reg_spill_if: bundles the spill/fill engine's control, register-file and
// memory-bus signals.
//   master modport: the engine (drives busy/done, register-file selects and
//                   write strobes, memory requests).
//   slave modport : the surroundings (control unit, register file, memory).
// Ports:
//   start, mode, baseAddr        operation request from the control unit
//   busy, done                   operation status
//   regA / dataA                 register-file read select / read data
//   progBank, dataBank           bank register values
//   regDest, dataOut, we, hb, lb register-file write port
//   memAddr, memWData, memWe,
//   memReq, memAck, memRData     word-wide memory request bus
interface reg_spill_if #(
  parameter int ADDR_W = 16
) ();
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] baseAddr;
  logic              busy;
  logic              done;
  logic [2:0]        regA;
  logic [15:0]       dataA;
  logic [7:0]        progBank;
  logic [7:0]        dataBank;
  logic [3:0]        regDest;
  logic [15:0]       dataOut;
  logic              we;
  logic              hb;
  logic              lb;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWData;
  logic              memWe;
  logic              memReq;
  logic              memAck;
  logic [15:0]       memRData;

  modport master (
    input  start, mode, baseAddr, dataA, progBank, dataBank, memAck, memRData,
    output busy, done, regA, regDest, dataOut, we, hb, lb,
           memAddr, memWData, memWe, memReq
  );

  modport slave (
    output start, mode, baseAddr, dataA, progBank, dataBank, memAck, memRData,
    input  busy, done, regA, regDest, dataOut, we, hb, lb,
           memAddr, memWData, memWe, memReq
  );
endinterface

// File: rtl/reg_spill.sv
// reg_spill: register spill/fill engine.
// A save walks GPR0..7 and then the bank pair, writing each to memory word
// base+idx. A restore reads the same nine words back and writes them into the
// register file (index 8 = {progBank, dataBank} via hb/lb).
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      reg_spill_if.master (control, register-file and memory signals)
module reg_spill #(
  parameter int ADDR_W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  reg_spill_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_REQ,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd8;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_idx;
  logic [3:0]        w_idx_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_base_next;
  logic              r_mode;
  logic              w_mode_next;
  logic [15:0]       r_wdata;
  logic [15:0]       w_wdata_next;
  logic [15:0]       r_rdata;
  logic [15:0]       w_rdata_next;
  logic              r_busy;
  logic              w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_base  <= '0;
      r_mode  <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_base  <= w_base_next;
      r_mode  <= w_mode_next;
      r_wdata <= w_wdata_next;
      r_rdata <= w_rdata_next;
      // busy tracks "not idle next cycle", so it rises after the start edge
      // and falls after the DONE cycle.
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_base_next  = r_base;
    w_mode_next  = r_mode;
    w_wdata_next = r_wdata;
    w_rdata_next = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mode_next  = bus.mode;
          w_base_next  = bus.baseAddr;
          w_idx_next   = '0;
          w_state_next = bus.mode ? S_REQ : S_RD;
        end
      end
      S_RD: begin
        // Capture the word to save; index 8 is the bank pair, not a GPR.
        w_wdata_next = w_last ? {bus.progBank, bus.dataBank} : bus.dataA;
        w_state_next = S_REQ;
      end
      S_REQ: begin
        if (bus.memAck) begin
          if (r_mode) begin
            w_rdata_next = bus.memRData;
            w_state_next = S_WR;
          end else if (w_last) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 4'd1;
            w_state_next = S_RD;
          end
        end
      end
      S_WR: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_idx_next   = r_idx + 4'd1;
          w_state_next = S_REQ;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Address wraps modulo 2^ADDR_W by construction of the adder width.
  assign bus.memAddr  = r_base + ADDR_W'(r_idx);
  assign bus.memWData = r_wdata;
  assign bus.memReq   = (r_state == S_REQ);
  assign bus.memWe    = (r_state == S_REQ) & ~r_mode;
  assign bus.regA     = r_idx[2:0];
  assign bus.regDest  = r_idx;
  assign bus.dataOut  = r_rdata;
  assign bus.we       = (r_state == S_WR);
  assign bus.hb       = (r_state == S_WR);
  assign bus.lb       = (r_state == S_WR);
  assign bus.done     = (r_state == S_DONE);
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_reg_spill.sv
module tb_reg_spill;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_spill_if #(.ADDR_W(ADDR_W)) sif ();
  reg_spill #(.ADDR_W(ADDR_W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(sif));

  // Register file and memory models
  logic [15:0] gpr [8];
  logic [7:0]  pb, db;
  logic [15:0] mem [65536];
  assign sif.dataA    = gpr[sif.regA];
  assign sif.progBank = pb;
  assign sif.dataBank = db;

  int vectors = 0;
  int miscompares = 0;

  // Per-operation observations
  int n_done, first_done, n_busy, n_we, n_req_cycles, wait_sum, stab_err, bytes_bad;
  bit aborted;
  logic [15:0] acc_addr [$];
  logic [15:0] acc_data [$];
  logic        acc_we   [$];
  logic [3:0]  wr_dest  [$];

  // Reference image: word i of the nine-word layout
  logic [15:0] img [9];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] addr_of(input logic [15:0] base, input int i);
    logic [15:0] a;
    a = base + 16'(i);
    return a;
  endfunction

  // One operation: start it, then serve the memory bus and register-file
  // write port cycle by cycle. wsel<0 draws 0..3 wait cycles per request.
  task automatic run_op(input bit m, input logic [15:0] base, input int wsel,
                        input bit pokes, input int rst_idx);
    int cyc, wcnt, cur_wait, tail;
    bit in_req, acc, smp_we, s_memwe, s_hb, s_lb;
    logic [15:0] h_addr, h_wdata, s_addr, s_wdata, s_dout;
    logic [3:0] s_dest;
    n_done = 0; first_done = -1; n_busy = 0; n_we = 0; n_req_cycles = 0;
    wait_sum = 0; stab_err = 0; bytes_bad = 0; aborted = 0;
    acc_addr.delete(); acc_data.delete(); acc_we.delete(); wr_dest.delete();
    cur_wait = (wsel < 0) ? int'($urandom_range(0, 3)) : wsel;
    wcnt = 0; in_req = 0; tail = -1; cyc = 0;
    h_addr = '0; h_wdata = '0;
    @(negedge clk);
    sif.start = 1'b1; sif.mode = m; sif.baseAddr = base; sif.memAck = pokes;
    @(posedge clk); #1;
    sif.start = 1'b0; sif.mode = ~m; sif.baseAddr = 16'($urandom);
    while (cyc < 400 && tail != 0) begin
      cyc++;
      @(negedge clk);
      if (sif.busy) n_busy++;
      if (sif.done) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
        tail = 3;
        if (pokes) sif.start = 1'b1;
      end else if (tail > 0) begin
        tail--;
      end
      if (pokes && cyc == 5) sif.start = 1'b1;
      acc = 0;
      if (sif.memReq) begin
        if (in_req && (sif.memAddr !== h_addr || sif.memWData !== h_wdata)) stab_err++;
        in_req = 1; h_addr = sif.memAddr; h_wdata = sif.memWData;
        n_req_cycles++;
        if (wcnt >= cur_wait) begin
          sif.memAck = 1'b1; sif.memRData = mem[sif.memAddr];
          acc = 1; wait_sum += cur_wait;
        end else begin
          sif.memAck = 1'b0; sif.memRData = 16'($urandom); wcnt++;
        end
      end else begin
        in_req = 0; wcnt = 0;
        cur_wait = (wsel < 0) ? int'($urandom_range(0, 3)) : wsel;
        sif.memAck = pokes; sif.memRData = 16'($urandom);
      end
      s_addr = sif.memAddr; s_wdata = sif.memWData; s_memwe = sif.memWe;
      smp_we = sif.we; s_dest = sif.regDest; s_dout = sif.dataOut;
      s_hb = sif.hb; s_lb = sif.lb;
      if (rst_idx >= 0 && smp_we && s_dest == 4'(rst_idx)) begin
        rst_n = 1'b0;
        #1;
        check("rst/we",       sif.we, 0);
        check("rst/memReq",   sif.memReq, 0);
        check("rst/busy",     sif.busy, 0);
        check("rst/done",     sif.done, 0);
        check("rst/hb_lb",    {sif.hb, sif.lb}, 0);
        check("rst/regDest",  sif.regDest, 0);
        check("rst/dataOut",  sif.dataOut, 0);
        check("rst/memWData", sif.memWData, 0);
        check("rst/memAddr",  sif.memAddr, 0);
        sif.memAck = 1'b0;
        @(posedge clk); #1;
        check("rst/we_held",  sif.we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      sif.start = 1'b0;
      if (acc) begin
        acc_addr.push_back(s_addr);
        acc_data.push_back(s_memwe ? s_wdata : mem[s_addr]);
        acc_we.push_back(s_memwe);
        if (s_memwe) mem[s_addr] = s_wdata;
      end
      if (smp_we) begin
        n_we++;
        wr_dest.push_back(s_dest);
        if (!(s_hb && s_lb)) bytes_bad++;
        if (s_dest < 4'd8) gpr[s_dest[2:0]] = s_dout;
        else begin
          if (s_hb) pb = s_dout[15:8];
          if (s_lb) db = s_dout[7:0];
        end
      end
    end
    sif.memAck = 1'b0;
    sif.start = 1'b0;
    if (!aborted) check("done_seen", first_done >= 0, 1);
  endtask

  task automatic snap_save_image();
    for (int i = 0; i < 8; i++) img[i] = gpr[i];
    img[8] = {pb, db};
  endtask

  task automatic verify_common(input string t, input int exp_done, input int exp_we);
    check({t, "/done_cycle"}, first_done, exp_done);
    check({t, "/n_done"}, n_done, 1);
    check({t, "/busy_cycles"}, n_busy, exp_done);
    check({t, "/n_we"}, n_we, exp_we);
    check({t, "/stable"}, stab_err, 0);
    check({t, "/req_cycles"}, n_req_cycles, 9 + wait_sum);
    check({t, "/n_acc"}, acc_addr.size(), 9);
  endtask

  task automatic verify_save(input string t, input logic [15:0] base, input int exp_done);
    verify_common(t, exp_done, 0);
    for (int i = 0; i < 9 && i < acc_addr.size(); i++) begin
      check($sformatf("%s/addr%0d", t, i), acc_addr[i], addr_of(base, i));
      check($sformatf("%s/data%0d", t, i), acc_data[i], img[i]);
      check($sformatf("%s/memWe%0d", t, i), acc_we[i], 1);
    end
  endtask

  task automatic verify_restore(input string t, input logic [15:0] base, input int exp_done);
    verify_common(t, exp_done, 9);
    check({t, "/hb_lb"}, bytes_bad, 0);
    for (int i = 0; i < 9 && i < acc_addr.size(); i++) begin
      check($sformatf("%s/addr%0d", t, i), acc_addr[i], addr_of(base, i));
      check($sformatf("%s/memWe%0d", t, i), acc_we[i], 0);
    end
    for (int i = 0; i < 9 && i < wr_dest.size(); i++)
      check($sformatf("%s/regDest%0d", t, i), wr_dest[i], i);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s/gpr%0d", t, i), gpr[i], img[i]);
    check({t, "/banks"}, {pb, db}, img[8]);
  endtask

  // Put a restore image into memory at base and remember it as expected.
  task automatic place_image(input logic [15:0] base, input bit rnd);
    logic [15:0] fixed_w [9];
    fixed_w = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0123,
                16'h4567, 16'h89AB, 16'hCDEF, 16'h1234};
    for (int i = 0; i < 9; i++) begin
      img[i] = rnd ? 16'($urandom) : fixed_w[i];
      mem[addr_of(base, i)] = img[i];
    end
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < 8; i++) gpr[i] = 16'($urandom);
    pb = 8'($urandom); db = 8'($urandom);
  endtask

  initial begin
    logic [15:0] b, old3;
    rst_n = 1'b0;
    sif.start = 1'b0; sif.mode = 1'b0; sif.baseAddr = '0;
    sif.memAck = 1'b0; sif.memRData = '0;
    for (int i = 0; i < 8; i++) gpr[i] = 16'h1110 * 16'(i + 1);
    pb = 8'hA5; db = 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy",     sif.busy, 0);
    check("reset/done",     sif.done, 0);
    check("reset/memReq",   sif.memReq, 0);
    check("reset/we_hb_lb", {sif.we, sif.hb, sif.lb}, 0);
    check("reset/regDest",  sif.regDest, 0);
    check("reset/dataOut",  sif.dataOut, 0);
    check("reset/memWData", sif.memWData, 0);
    check("reset/memAddr",  sif.memAddr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Save, zero-wait, known pattern
    snap_save_image();
    run_op(1'b0, 16'h0100, 0, 1'b0, -1);
    verify_save("save0", 16'h0100, 19);

    // Restore, zero-wait, known image
    place_image(16'h0200, 1'b0);
    run_op(1'b1, 16'h0200, 0, 1'b0, -1);
    verify_restore("rest0", 16'h0200, 19);

    // Three wait cycles on every request
    randomize_rf(); snap_save_image();
    b = 16'($urandom);
    run_op(1'b0, b, 3, 1'b0, -1);
    verify_save("save_w3", b, 46);

    // Address wrap
    randomize_rf(); snap_save_image();
    run_op(1'b0, 16'hFFFC, 0, 1'b0, -1);
    verify_save("wrap", 16'hFFFC, 19);

    // Stray start pulses and acks
    randomize_rf(); snap_save_image();
    run_op(1'b0, 16'h4000, 0, 1'b1, -1);
    verify_save("pokes_save", 16'h4000, 19);
    b = 16'($urandom);
    place_image(b, 1'b1);
    run_op(1'b1, b, -1, 1'b1, -1);
    verify_restore("pokes_rest", b, 19 + wait_sum);

    // Randomized save/restore with random wait states
    for (int k = 0; k < 4; k++) begin
      b = 16'($urandom);
      if (k % 2 == 0) begin
        randomize_rf(); snap_save_image();
        run_op(1'b0, b, -1, 1'b0, -1);
        verify_save($sformatf("rnd_save%0d", k), b, 19 + wait_sum);
      end else begin
        place_image(b, 1'b1);
        run_op(1'b1, b, -1, 1'b0, -1);
        verify_restore($sformatf("rnd_rest%0d", k), b, 19 + wait_sum);
      end
    end

    // Reset during the WR of idx 3, then a clean restart
    randomize_rf();
    old3 = gpr[3];
    place_image(16'h3000, 1'b1);
    run_op(1'b1, 16'h3000, 0, 1'b0, 3);
    check("rst/aborted", aborted, 1);
    for (int i = 0; i < 3; i++) check($sformatf("rst/gpr%0d", i), gpr[i], img[i]);
    check("rst/gpr3_untouched", gpr[3], old3);
    repeat (2) @(negedge clk);
    snap_save_image();
    run_op(1'b0, 16'h5000, 0, 1'b0, -1);
    verify_save("after_rst", 16'h5000, 19);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
